// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller:
// geometry, FSM state encoding and address-split helpers.
package dcache_ctrl_pkg;

  localparam int LINE_WIDTH  = 6;
  localparam int INDEX_WIDTH = 6;
  localparam int TAG_WIDTH   = 32 - LINE_WIDTH - INDEX_WIDTH;
  localparam int OFF_WIDTH   = LINE_WIDTH - 2;

  localparam logic [OFF_WIDTH-1:0] OFF_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB_RD,
    ST_WB,
    ST_FILL,
    ST_REPLAY
  } state_e;

  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [31:0] addr);
    return addr[31 -: TAG_WIDTH];
  endfunction

  function automatic logic [INDEX_WIDTH-1:0] addr_idx(input logic [31:0] addr);
    return addr[LINE_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic logic [OFF_WIDTH-1:0] addr_off(input logic [31:0] addr);
    return addr[LINE_WIDTH-1:2];
  endfunction

endpackage

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller sequencing an
// external line storage array and a single-word memory bus.
//
//   state  | meaning
//   IDLE   | waiting for cpu_req; storage addressed from cpu_addr
//   LOOKUP | tag compare; hit completes the access, miss starts eviction/refill
//   WB_RD  | read victim word cnt (one-cycle storage latency)
//   WB     | write victim word cnt to memory
//   FILL   | read word cnt from memory into the line
//   REPLAY | re-address the requested word before the guaranteed-hit lookup
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_be,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_ack,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_ack,
  output logic [INDEX_WIDTH-1:0] ln_idx,
  output logic [OFF_WIDTH-1:0]   ln_rd_off,
  input  logic [TAG_WIDTH-1:0]   ln_rd_tag,
  input  logic                   ln_rd_valid,
  input  logic                   ln_rd_dirty,
  input  logic [31:0]            ln_rd_data,
  output logic                   ln_wr_write,
  output logic [TAG_WIDTH-1:0]   ln_wr_tag,
  output logic [OFF_WIDTH-1:0]   ln_wr_off,
  output logic [31:0]            ln_wr_data,
  output logic [3:0]             ln_wr_be,
  output logic                   ln_wr_dirty,
  output logic                   ln_wr_valid
);

  state_e                 state_q, state_d;
  logic [OFF_WIDTH-1:0]   cnt_q, cnt_d;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic [3:0]             be_q;
  logic                   we_q;
  logic [TAG_WIDTH-1:0]   old_tag_q;
  logic                   hit;
  logic                   cnt_last;

  assign hit      = ln_rd_valid && (ln_rd_tag == addr_tag(addr_q));
  assign cnt_last = (cnt_q == OFF_MAX);

  // Storage keeps re-reading offset cnt during WB, so its output register holds the victim word.
  assign mem_wdata = ln_rd_data;
  assign cpu_rdata = ln_rd_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_ack     = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    ln_idx      = addr_idx(addr_q);
    ln_rd_off   = addr_off(addr_q);
    ln_wr_write = 1'b0;
    ln_wr_tag   = addr_tag(addr_q);
    ln_wr_off   = addr_off(addr_q);
    ln_wr_data  = wdata_q;
    ln_wr_be    = be_q;
    ln_wr_dirty = 1'b0;
    ln_wr_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ln_idx    = addr_idx(cpu_addr);
        ln_rd_off = addr_off(cpu_addr);
        if (cpu_req) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu_ack = 1'b1;
          state_d = ST_IDLE;
          if (we_q) begin
            ln_wr_write = 1'b1;
            ln_wr_dirty = 1'b1;
            ln_wr_valid = 1'b1;
          end
        end else begin
          cnt_d   = '0;
          state_d = (ln_rd_valid && ln_rd_dirty) ? ST_WB_RD : ST_FILL;
        end
      end
      ST_WB_RD: begin
        ln_rd_off = cnt_q;
        state_d   = ST_WB;
      end
      ST_WB: begin
        ln_rd_off = cnt_q;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {old_tag_q, addr_idx(addr_q), cnt_q, 2'b00};
        if (mem_ack) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_FILL;
          end else begin
            cnt_d   = cnt_q + OFF_WIDTH'(1);
            state_d = ST_WB_RD;
          end
        end
      end
      ST_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_tag(addr_q), addr_idx(addr_q), cnt_q, 2'b00};
        if (mem_ack) begin
          ln_wr_write = 1'b1;
          ln_wr_off   = cnt_q;
          ln_wr_data  = mem_rdata;
          ln_wr_be    = 4'hF;
          ln_wr_valid = cnt_last;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = ST_REPLAY;
          end else begin
            cnt_d = cnt_q + OFF_WIDTH'(1);
          end
        end
      end
      ST_REPLAY: state_d = ST_LOOKUP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      old_tag_q <= '0;
    end else begin
      if (state_q == ST_IDLE && cpu_req) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        be_q    <= cpu_be;
        we_q    <= cpu_we;
      end
      if (state_q == ST_LOOKUP) old_tag_q <= ln_rd_tag;
    end
  end

endmodule
